// File: rtl/mem_seq_ctrl_pkg.sv
// Shared encodings for the memory-block sequencer: FSM states, instruction
// classes, ALU phases and mux select codes.
package mem_seq_ctrl_pkg;

    localparam int WE_W_DEF    = 4;
    localparam int A1SEL_W_DEF = 2;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MEM_RD = 4'd3,
        ST_MEM_WR = 4'd4,
        ST_WB     = 4'd5,
        ST_LINK   = 4'd6,
        ST_PC_JMP = 4'd7,
        ST_TRAP   = 4'd8
    } state_e;

    localparam logic [2:0] CLS_OP     = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_JUMP   = 3'd4;

    localparam logic [2:0] PH_PC_INC   = 3'd0;
    localparam logic [2:0] PH_EXEC     = 3'd1;
    localparam logic [2:0] PH_ADDR     = 3'd2;
    localparam logic [2:0] PH_TARGET   = 3'd3;
    localparam logic [2:0] PH_PASS_MDR = 3'd4;

    localparam logic [1:0] A1_CU  = 2'd0;
    localparam logic [1:0] A1_PC  = 2'd1;
    localparam logic [1:0] A1_ALU = 2'd2;

    localparam logic A2_CU  = 1'b0;
    localparam logic W1_R2  = 1'b1;
    localparam logic W1_ALU = 1'b0;
    localparam logic W2_ALU = 1'b0;
    localparam logic W2_PC  = 1'b1;

    function automatic logic is_mem_class(input logic [2:0] cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/mem_seq_ctrl_be_gen.sv
// Byte-lane write mask and access-fault detection for a data access of the
// size encoded in funct3[1:0] at byte offset addr_lo.
module mem_seq_ctrl_be_gen #(
    parameter int WE_W = 4
) (
    input  logic [1:0]      size,
    input  logic [1:0]      addr_lo,
    output logic [WE_W-1:0] mask,
    output logic            fault
);

    logic is_byte;
    logic is_half;
    logic is_word;
    logic misalign;
    logic illegal;

    assign is_byte = (size == 2'b00);
    assign is_half = (size == 2'b01);
    assign is_word = (size == 2'b10);
    assign illegal = (size == 2'b11);

    assign misalign = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
    assign fault    = misalign || illegal;

    // A half-word occupies the lane pair selected by addr_lo[1].
    for (genvar gi = 0; gi < WE_W; gi++) begin : g_lane
        assign mask[gi] = (is_byte && (32'(addr_lo) == gi))
                       || (is_half && (32'(addr_lo[1]) == gi / 2))
                       || is_word;
    end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Multicycle sequencer for the memory block: steps each instruction through
// FETCH/DECODE/... and decodes mux selects, write strobes and ALU phase.
module mem_seq_ctrl
    import mem_seq_ctrl_pkg::*;
#(
    parameter int WE_W    = WE_W_DEF,
    parameter int A1SEL_W = A1SEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [2:0]         instr_class,
    input  logic [2:0]         funct3,
    input  logic [1:0]         addr_lo,
    input  logic               branch_taken,
    output logic [A1SEL_W-1:0] A1_mux_control,
    output logic               A2_mux_control,
    output logic               W1_mux_control,
    output logic               W2_mux_control,
    output logic [WE_W-1:0]    WE1,
    output logic [WE_W-1:0]    WE2,
    output logic               pc_WE,
    output logic               old_pc_WE,
    output logic               ir_WE,
    output logic               mdr_WE,
    output logic [2:0]         alu_phase,
    output logic               trap
);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] cls_q;
    logic [2:0] cls_d;
    logic       trap_q;
    logic       trap_d;

    logic [WE_W-1:0] byte_mask;
    logic            acc_fault;

    // funct3[2] only distinguishes signed/unsigned loads, which the CU handles.
    logic unused_funct3_hi;
    assign unused_funct3_hi = funct3[2];

    mem_seq_ctrl_be_gen #(
        .WE_W(WE_W)
    ) u_be_gen (
        .size   (funct3[1:0]),
        .addr_lo(addr_lo),
        .mask   (byte_mask),
        .fault  (acc_fault)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_OP;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_d = instr_class;
                case (instr_class)
                    CLS_OP, CLS_BRANCH: state_d = ST_EXEC;
                    CLS_LOAD:           state_d = ST_MEM_RD;
                    CLS_STORE:          state_d = ST_MEM_WR;
                    CLS_JUMP:           state_d = ST_LINK;
                    default:            state_d = ST_TRAP;
                endcase
            end
            ST_EXEC:   state_d = (cls_q == CLS_OP) ? ST_WB : ST_FETCH;
            ST_MEM_RD: state_d = acc_fault ? ST_TRAP : ST_WB;
            ST_MEM_WR: state_d = acc_fault ? ST_TRAP : ST_FETCH;
            ST_WB:     state_d = ST_FETCH;
            ST_LINK:   state_d = ST_PC_JMP;
            ST_PC_JMP: state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_FETCH;
        endcase
        trap_d = trap_q || (state_d == ST_TRAP);
    end

    always_comb begin
        A1_mux_control = A1SEL_W'(A1_CU);
        A2_mux_control = A2_CU;
        W1_mux_control = W1_ALU;
        W2_mux_control = W2_ALU;
        WE1            = '0;
        WE2            = '0;
        pc_WE          = 1'b0;
        old_pc_WE      = 1'b0;
        ir_WE          = 1'b0;
        mdr_WE         = 1'b0;
        alu_phase      = PH_PC_INC;
        case (state_q)
            ST_FETCH: begin
                A1_mux_control = A1SEL_W'(A1_PC);
                // Reset forces this state, so gating here keeps strobes quiet in reset.
                if (run && !rst) begin
                    ir_WE     = 1'b1;
                    old_pc_WE = 1'b1;
                    pc_WE     = 1'b1;
                end
            end
            ST_DECODE: begin
                if (is_mem_class(instr_class)) begin
                    alu_phase = PH_ADDR;
                end
            end
            ST_EXEC: begin
                alu_phase = PH_EXEC;
                if ((cls_q == CLS_BRANCH) && branch_taken) begin
                    alu_phase = PH_TARGET;
                    pc_WE     = 1'b1;
                end
            end
            ST_MEM_RD: begin
                A1_mux_control = A1SEL_W'(A1_ALU);
                alu_phase      = PH_ADDR;
                mdr_WE         = !acc_fault;
            end
            ST_MEM_WR: begin
                A1_mux_control = A1SEL_W'(A1_ALU);
                W1_mux_control = W1_R2;
                alu_phase      = PH_ADDR;
                if (!acc_fault) begin
                    WE1 = byte_mask;
                end
            end
            ST_WB: begin
                WE2       = '1;
                alu_phase = (cls_q == CLS_LOAD) ? PH_PASS_MDR : PH_EXEC;
            end
            ST_LINK: begin
                W2_mux_control = W2_PC;
                WE2            = '1;
            end
            ST_PC_JMP: begin
                alu_phase = PH_TARGET;
                pc_WE     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign trap = trap_q;

endmodule
